// File: rtl/gcd_binary_unit_pkg.sv
// Shared types and width helpers for the binary (Stein) GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // K never exceeds WL-1, one extra bit keeps the increment from wrapping
    function automatic int kw_of(input int wl);
        return $clog2(wl) + 1;
    endfunction

    function automatic int cw_of(input int wl);
        return $clog2(2 * wl + 2);
    endfunction

endpackage

// File: rtl/gcd_binary_unit_if.sv
// Operand/result handshake bundle between producer, GCD engine and consumer.
interface gcd_binary_unit_if #(
    parameter int WL = 8
);
    localparam int CW = gcd_pkg::cw_of(WL);

    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] op_a;
    logic [WL-1:0] op_b;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] res;
    logic [CW-1:0] iters;

    modport master (
        output clr, in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, res, iters
    );

    modport slave (
        input  clr, in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, res, iters
    );

endinterface

// File: rtl/gcd_binary_unit_step.sv
// One combinational Stein step: reduces (A, B, K) or reports the final gcd.
module gcd_bin_step #(
    parameter int WL = 8,
    parameter int KW = gcd_pkg::kw_of(WL)
) (
    input  logic [WL-1:0] i_a,
    input  logic [WL-1:0] i_b,
    input  logic [KW-1:0] i_k,
    output logic [WL-1:0] o_a,
    output logic [WL-1:0] o_b,
    output logic [KW-1:0] o_k,
    output logic          o_done,
    output logic [WL-1:0] o_res
);

    always_comb begin
        o_a    = i_a;
        o_b    = i_b;
        o_k    = i_k;
        o_done = 1'b0;
        o_res  = '0;
        if (i_a == '0) begin
            o_done = 1'b1;
            o_res  = i_b << i_k;
        end else if (i_b == '0) begin
            o_done = 1'b1;
            o_res  = i_a << i_k;
        end else if (!i_a[0] && !i_b[0]) begin
            o_a = i_a >> 1;
            o_b = i_b >> 1;
            o_k = i_k + KW'(1);
        end else if (!i_a[0]) begin
            o_a = i_a >> 1;
        end else if (!i_b[0]) begin
            o_b = i_b >> 1;
        end else if (i_a >= i_b) begin
            // difference of two odds is even, so the halving is exact
            o_a = (i_a - i_b) >> 1;
        end else begin
            o_b = (i_b - i_a) >> 1;
        end
    end

endmodule

// File: rtl/gcd_binary_unit.sv
// Binary GCD engine: FSM, operand/result registers, iteration counter, handshakes.
module gcd_binary_unit
    import gcd_pkg::*;
#(
    parameter int WL = 8
) (
    input logic              clk,
    input logic              rst,
    gcd_binary_unit_if.slave bus
);
    localparam int KW = kw_of(WL);
    localparam int CW = cw_of(WL);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [WL-1:0] r_a;
    logic [WL-1:0] r_b;
    logic [WL-1:0] r_res;
    logic [KW-1:0] r_k;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_iters;
    logic [WL-1:0] w_a;
    logic [WL-1:0] w_b;
    logic [WL-1:0] w_res;
    logic [KW-1:0] w_k;
    logic          w_done;
    logic          w_accept;

    gcd_bin_step #(.WL(WL), .KW(KW)) u_step (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_k    (r_k),
        .o_a    (w_a),
        .o_b    (w_b),
        .o_k    (w_k),
        .o_done (w_done),
        .o_res  (w_res)
    );

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.in_valid) w_state_nxt = S_CALC;
                S_CALC:  if (w_done) w_state_nxt = S_DONE;
                S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_iters <= '0;
        end else if (bus.clr) begin
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_iters <= '0;
        end else if (w_accept) begin
            r_a   <= bus.op_a;
            r_b   <= bus.op_b;
            r_k   <= '0;
            r_cnt <= '0;
        end else if (r_state == S_CALC) begin
            // the terminating step counts too, hence cnt+1 into iters
            r_cnt <= r_cnt + CW'(1);
            if (w_done) begin
                r_res   <= w_res;
                r_iters <= r_cnt + CW'(1);
            end else begin
                r_a <= w_a;
                r_b <= w_b;
                r_k <= w_k;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.res       = r_res;
    assign bus.iters     = r_iters;

endmodule

// File: tb/tb_gcd_binary_unit.sv
// Self-checking bench for gcd_binary_unit at WL=8 and WL=16.
module tb_gcd_binary_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    gcd_binary_unit_if #(.WL(8))  if8 ();
    gcd_binary_unit_if #(.WL(16)) if16 ();

    gcd_binary_unit #(.WL(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    gcd_binary_unit #(.WL(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         iters;
    } vec_t;

    vec_t vecs[9];

    function automatic longint ref_gcd(input longint x, input longint y);
        longint p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // caller is at a negedge; returns at the first negedge with out_valid (or timeout)
    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input logic ordy,
                        output logic [7:0] r, output int it, output int n);
        int w;
        w = 0;
        while (!if8.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("txn8_in_ready", if8.in_ready, 1);
        if8.op_a      = a;
        if8.op_b      = b;
        if8.in_valid  = 1'b1;
        if8.out_ready = ordy;
        @(negedge clk);
        if8.in_valid = 1'b0;
        n = 0;
        while (!if8.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        r  = if8.res;
        it = int'(if8.iters);
    endtask

    task automatic txn16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output int it, output int n);
        int w;
        w = 0;
        while (!if16.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("txn16_in_ready", if16.in_ready, 1);
        if16.op_a      = a;
        if16.op_b      = b;
        if16.in_valid  = 1'b1;
        if16.out_ready = 1'b1;
        @(negedge clk);
        if16.in_valid = 1'b0;
        n = 0;
        while (!if16.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        r  = if16.res;
        it = int'(if16.iters);
    endtask

    initial begin
        logic [7:0]  r8;
        logic [15:0] r16;
        logic [7:0]  a8, b8;
        logic [15:0] a16, b16;
        int          it, n;

        total = 0;
        bad   = 0;
        vecs[0] = '{8'd12,  8'd18,  8'd6,   5};
        vecs[1] = '{8'd0,   8'd0,   8'd0,   1};
        vecs[2] = '{8'd0,   8'd7,   8'd7,   1};
        vecs[3] = '{8'd9,   8'd0,   8'd9,   1};
        vecs[4] = '{8'd255, 8'd1,   8'd1,   9};
        vecs[5] = '{8'd1,   8'd255, 8'd1,   9};
        vecs[6] = '{8'd100, 8'd75,  8'd25,  5};
        vecs[7] = '{8'd128, 8'd128, 8'd128, 9};
        vecs[8] = '{8'd7,   8'd7,   8'd7,   2};

        if8.clr = 1'b0;  if8.in_valid = 1'b0;  if8.op_a = '0;  if8.op_b = '0;  if8.out_ready = 1'b1;
        if16.clr = 1'b0; if16.in_valid = 1'b0; if16.op_a = '0; if16.op_b = '0; if16.out_ready = 1'b1;

        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready",  if8.in_ready, 1);
        check("rst_out_valid", if8.out_valid, 0);
        check("rst_res",       if8.res, 0);
        check("rst_iters",     if8.iters, 0);
        check("rst16_in_ready", if16.in_ready, 1);
        check("rst16_out_valid", if16.out_valid, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            txn8(vecs[i].a, vecs[i].b, 1'b1, r8, it, n);
            check($sformatf("vec%0d_res", i), r8, vecs[i].res);
            check($sformatf("vec%0d_iters", i), it, vecs[i].iters);
            check($sformatf("vec%0d_latency", i), n, vecs[i].iters);
            check($sformatf("vec%0d_ref", i), r8, ref_gcd(vecs[i].a, vecs[i].b));
        end

        // consumer stalls: result must hold, new operands must be ignored
        txn8(8'd12, 8'd18, 1'b0, r8, it, n);
        check("hold_first_res", r8, 6);
        for (int i = 0; i < 10; i++) begin
            if8.in_valid = i[0];
            if8.op_a     = 8'($urandom);
            if8.op_b     = 8'($urandom);
            @(negedge clk);
            check("hold_out_valid", if8.out_valid, 1);
            check("hold_res",       if8.res, 6);
            check("hold_iters",     if8.iters, 5);
            check("hold_in_ready",  if8.in_ready, 0);
        end
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", if8.out_valid, 0);
        check("release_in_ready",  if8.in_ready, 1);

        // clr beats in_valid in IDLE
        if8.in_valid = 1'b1;
        if8.op_a     = 8'd12;
        if8.op_b     = 8'd18;
        if8.clr      = 1'b1;
        @(negedge clk);
        if8.clr      = 1'b0;
        if8.in_valid = 1'b0;
        check("clr_prio_in_ready", if8.in_ready, 1);

        // clr on the 3rd CALC cycle
        if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("clr_pre_in_ready", if8.in_ready, 0);
        if8.clr = 1'b1;
        @(negedge clk);
        if8.clr = 1'b0;
        check("clr_in_ready",  if8.in_ready, 1);
        check("clr_out_valid", if8.out_valid, 0);
        check("clr_res",       if8.res, 0);
        check("clr_iters",     if8.iters, 0);
        txn8(8'd100, 8'd75, 1'b1, r8, it, n);
        check("post_clr_res",   r8, 25);
        check("post_clr_iters", it, 5);

        // async reset mid-CALC
        @(negedge clk);
        if8.op_a     = 8'd255;
        if8.op_b     = 8'd1;
        if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("arst_pre_in_ready", if8.in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready",  if8.in_ready, 1);
        check("arst_out_valid", if8.out_valid, 0);
        check("arst_res",       if8.res, 0);
        check("arst_iters",     if8.iters, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn8(8'd7, 8'd7, 1'b1, r8, it, n);
        check("post_arst_res",   r8, 7);
        check("post_arst_iters", it, 2);

        for (int i = 0; i < 40; i++) begin
            a8 = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
            b8 = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
            txn8(a8, b8, 1'b1, r8, it, n);
            check($sformatf("rnd8_res(%0d,%0d)", a8, b8), r8, ref_gcd(a8, b8));
            check("rnd8_latency", n, it);
            check("rnd8_bound", (it >= 1 && it <= 17), 1);
        end

        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            a16 = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
            b16 = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
            if (i == 0) begin
                a16 = 16'hFFFF;
                b16 = 16'd1;
            end
            txn16(a16, b16, r16, it, n);
            check($sformatf("rnd16_res(%0d,%0d)", a16, b16), r16, ref_gcd(a16, b16));
            check("rnd16_latency", n, it);
            check("rnd16_bound", (it >= 1 && it <= 33), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
